// File: rtl/simd_alu_pkg.sv
// Shared constants and types for the SIMD ALU: lane-size modes, compare opcodes
// and 8-bit segment helpers.
package simd_alu_pkg;

  localparam logic [1:0] MODE_8  = 2'd0;
  localparam logic [1:0] MODE_16 = 2'd1;
  localparam logic [1:0] MODE_32 = 2'd2;
  localparam logic [1:0] MODE_64 = 2'd3;

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0,
    CMP_NE = 3'd1,
    CMP_GT = 3'd2,
    CMP_GE = 3'd3,
    CMP_LT = 3'd4,
    CMP_LE = 3'd5
  } cmp_op_e;

  localparam int SEG_W     = 8;
  localparam int SEG_COUNT = 256 / SEG_W;

  function automatic int seg_count(input int width);
    return width / SEG_W;
  endfunction

endpackage

// File: rtl/simd_cmp_seg_combine.sv
// Merges per-byte equal/greater-than flags into per-lane equal/greater-than flags
// for the selected lane size; lane j of the current mode is reported at index j.
module simd_cmp_seg_combine
  import simd_alu_pkg::*;
#(
  parameter int NSEG = SEG_COUNT
) (
  input  logic [NSEG-1:0] seg_eq_i,
  input  logic [NSEG-1:0] seg_gt_i,
  input  logic [NSEG-1:0] msb_a_i,
  input  logic [NSEG-1:0] msb_b_i,
  input  logic [1:0]      data_mode_i,
  input  logic            signed_i,
  output logic [NSEG-1:0] lane_eq_o,
  output logic [NSEG-1:0] lane_gt_o
);

  logic [NSEG/2-1:0] eq16, gt16;
  logic [NSEG/4-1:0] eq32, gt32;
  logic [NSEG/8-1:0] eq64, gt64;

  // Unsigned magnitude: the upper half decides unless it is equal.
  always_comb begin
    eq16 = '0;
    gt16 = '0;
    eq32 = '0;
    gt32 = '0;
    eq64 = '0;
    gt64 = '0;
    for (int j = 0; j < NSEG/2; j++) begin
      eq16[j] = seg_eq_i[2*j+1] & seg_eq_i[2*j];
      gt16[j] = seg_gt_i[2*j+1] | (seg_eq_i[2*j+1] & seg_gt_i[2*j]);
    end
    for (int j = 0; j < NSEG/4; j++) begin
      eq32[j] = eq16[2*j+1] & eq16[2*j];
      gt32[j] = gt16[2*j+1] | (eq16[2*j+1] & gt16[2*j]);
    end
    for (int j = 0; j < NSEG/8; j++) begin
      eq64[j] = eq32[2*j+1] & eq32[2*j];
      gt64[j] = gt32[2*j+1] | (eq32[2*j+1] & gt32[2*j]);
    end
  end

  // When signs differ, a is greater exactly when b is the negative one.
  function automatic logic fix_gt(input logic ugt, input logic ma, input logic mb,
                                  input logic sgn);
    return (sgn && (ma != mb)) ? mb : ugt;
  endfunction

  always_comb begin
    lane_eq_o = '0;
    lane_gt_o = '0;
    case (data_mode_i)
      MODE_8: begin
        for (int j = 0; j < NSEG; j++) begin
          lane_eq_o[j] = seg_eq_i[j];
          lane_gt_o[j] = fix_gt(seg_gt_i[j], msb_a_i[j], msb_b_i[j], signed_i);
        end
      end
      MODE_16: begin
        for (int j = 0; j < NSEG/2; j++) begin
          lane_eq_o[j] = eq16[j];
          lane_gt_o[j] = fix_gt(gt16[j], msb_a_i[2*j+1], msb_b_i[2*j+1], signed_i);
        end
      end
      MODE_32: begin
        for (int j = 0; j < NSEG/4; j++) begin
          lane_eq_o[j] = eq32[j];
          lane_gt_o[j] = fix_gt(gt32[j], msb_a_i[4*j+3], msb_b_i[4*j+3], signed_i);
        end
      end
      default: begin
        for (int j = 0; j < NSEG/8; j++) begin
          lane_eq_o[j] = eq64[j];
          lane_gt_o[j] = fix_gt(gt64[j], msb_a_i[8*j+7], msb_b_i[8*j+7], signed_i);
        end
      end
    endcase
  end

endmodule

// File: rtl/simd_alu_comparer_pipe.sv
// Two-stage valid/ready SIMD lane comparator: S1 registers byte-level compare
// flags, S2 folds them into lanes and registers result, mask and reductions.
module simd_alu_comparer_pipe
  import simd_alu_pkg::*;
#(
  parameter int SIMD_DATA_WIDTH            = 256,
  parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2,
  parameter bit MASK_FORMAT                = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SIMD_DATA_WIDTH-1:0]            a,
  input  logic [SIMD_DATA_WIDTH-1:0]            b,
  input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] data_mode,
  input  logic [2:0]                            cmp_op,
  input  logic                                  signed_cmp,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SIMD_DATA_WIDTH-1:0]            result,
  output logic [SIMD_DATA_WIDTH/8-1:0]          lane_mask,
  output logic                                  any_true,
  output logic                                  all_true
);

  localparam int NSEG = seg_count(SIMD_DATA_WIDTH);

  logic s1_en, s2_en;
  logic vld_p1_q, vld_p2_q;

  logic [NSEG-1:0] seg_eq_d, seg_gt_d, msb_a_d, msb_b_d;
  logic [NSEG-1:0] seg_eq_p1_q, seg_gt_p1_q, msb_a_p1_q, msb_b_p1_q;
  logic [1:0]      mode_p1_q;
  logic [2:0]      op_p1_q;
  logic            sgn_p1_q;

  logic [NSEG-1:0]            lane_eq, lane_gt;
  logic [NSEG-1:0]            lane_true_d, lane_exist_d;
  logic [SIMD_DATA_WIDTH-1:0] result_d;
  logic                       any_d, all_d;

  logic [SIMD_DATA_WIDTH-1:0] result_p2_q;
  logic [NSEG-1:0]            mask_p2_q;
  logic                       any_p2_q, all_p2_q;

  assign s2_en    = !vld_p2_q || out_ready;
  assign s1_en    = !vld_p1_q || s2_en;
  assign in_ready = s1_en && !rst;

  always_comb begin
    seg_eq_d = '0;
    seg_gt_d = '0;
    msb_a_d  = '0;
    msb_b_d  = '0;
    for (int s = 0; s < NSEG; s++) begin
      seg_eq_d[s] = a[s*SEG_W +: SEG_W] == b[s*SEG_W +: SEG_W];
      seg_gt_d[s] = a[s*SEG_W +: SEG_W] >  b[s*SEG_W +: SEG_W];
      msb_a_d[s]  = a[s*SEG_W + SEG_W - 1];
      msb_b_d[s]  = b[s*SEG_W + SEG_W - 1];
    end
  end

  // ---- S1: byte flags and operation fields ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else if (s1_en) begin
      vld_p1_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_en && in_valid) begin
      seg_eq_p1_q <= seg_eq_d;
      seg_gt_p1_q <= seg_gt_d;
      msb_a_p1_q  <= msb_a_d;
      msb_b_p1_q  <= msb_b_d;
      mode_p1_q   <= data_mode[1:0];
      op_p1_q     <= cmp_op;
      sgn_p1_q    <= signed_cmp;
    end
  end

  simd_cmp_seg_combine #(
    .NSEG (NSEG)
  ) u_combine (
    .seg_eq_i    (seg_eq_p1_q),
    .seg_gt_i    (seg_gt_p1_q),
    .msb_a_i     (msb_a_p1_q),
    .msb_b_i     (msb_b_p1_q),
    .data_mode_i (mode_p1_q),
    .signed_i    (sgn_p1_q),
    .lane_eq_o   (lane_eq),
    .lane_gt_o   (lane_gt)
  );

  function automatic logic [SEG_W-1:0] lane_fill(input logic truth, input logic low_seg);
    logic [SEG_W-1:0] one;
    one = {{(SEG_W-1){1'b0}}, 1'b1};
    if (!truth) return '0;
    if (MASK_FORMAT) return '1;
    return low_seg ? one : '0;
  endfunction

  always_comb begin
    int  sh;
    int  lane_cnt;
    int  j;
    logic t;
    lane_true_d  = '0;
    lane_exist_d = '0;
    result_d     = '0;
    sh       = int'(mode_p1_q);
    lane_cnt = NSEG >> sh;
    for (int l = 0; l < NSEG; l++) begin
      t = 1'b0;
      case (op_p1_q)
        CMP_EQ:  t = lane_eq[l];
        CMP_NE:  t = !lane_eq[l];
        CMP_GT:  t = lane_gt[l];
        CMP_GE:  t = lane_gt[l] || lane_eq[l];
        CMP_LT:  t = !(lane_gt[l] || lane_eq[l]);
        CMP_LE:  t = !lane_gt[l];
        default: t = 1'b0;
      endcase
      lane_exist_d[l] = l < lane_cnt;
      lane_true_d[l]  = t && lane_exist_d[l];
    end
    for (int s = 0; s < NSEG; s++) begin
      j = s >> sh;
      result_d[s*SEG_W +: SEG_W] = lane_fill(lane_true_d[j], (s & ((1 << sh) - 1)) == 0);
    end
    any_d = |lane_true_d;
    all_d = lane_true_d == lane_exist_d;
  end

  // ---- S2: lane results and reductions ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q    <= 1'b0;
      result_p2_q <= '0;
      mask_p2_q   <= '0;
      any_p2_q    <= 1'b0;
      all_p2_q    <= 1'b0;
    end else if (s2_en) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        result_p2_q <= result_d;
        mask_p2_q   <= lane_true_d;
        any_p2_q    <= any_d;
        all_p2_q    <= all_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign result    = result_p2_q;
  assign lane_mask = mask_p2_q;
  assign any_true  = any_p2_q;
  assign all_true  = all_p2_q;

endmodule

// File: tb/tb_simd_alu_comparer_pipe.sv
// Scoreboard bench: two comparer instances (all-ones and zero-extended true
// lanes) share stimulus; a monitor pops expected beats as results leave.
module tb_simd_alu_comparer_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [255:0] a, b;
  logic [1:0]   data_mode;
  logic [2:0]   cmp_op;
  logic         signed_cmp;
  logic         out_ready;

  logic         in_ready, out_valid, any_true, all_true;
  logic [255:0] result;
  logic [31:0]  lane_mask;
  logic         in_ready0, out_valid0, any_true0, all_true0;
  logic [255:0] result0;
  logic [31:0]  lane_mask0;

  always #5 clk = ~clk;

  simd_alu_comparer_pipe #(
    .SIMD_DATA_WIDTH(256), .SIMD_ADDER_DATA_MODE_WIDTH(2), .MASK_FORMAT(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .data_mode(data_mode), .cmp_op(cmp_op), .signed_cmp(signed_cmp),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .lane_mask(lane_mask), .any_true(any_true), .all_true(all_true)
  );

  simd_alu_comparer_pipe #(
    .SIMD_DATA_WIDTH(256), .SIMD_ADDER_DATA_MODE_WIDTH(2), .MASK_FORMAT(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .data_mode(data_mode), .cmp_op(cmp_op), .signed_cmp(signed_cmp),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0),
    .lane_mask(lane_mask0), .any_true(any_true0), .all_true(all_true0)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] mask;
    logic        any;
    logic        all;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  logic         prev_stall = 1'b0;
  logic [255:0] held_result;
  logic [31:0]  held_mask;
  logic [1:0]   held_flags;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // True lane k/w sets every bit of its lane (fmt=1) or only its lowest bit.
  function automatic logic [255:0] expand(input bit fmt, input logic [1:0] mode,
                                          input logic [31:0] mask);
    logic [255:0] r;
    int w;
    r = '0;
    w = 8 << mode;
    for (int k = 0; k < 256; k++)
      if (mask[k/w] && (fmt || (k % w) == 0)) r[k] = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("pair_handshake", {254'd0, in_ready0, out_valid0}, {254'd0, in_ready, out_valid});
      if (out_valid) begin
        if (prev_stall) begin
          check("stall_result", result, held_result);
          check("stall_mask", {224'd0, lane_mask}, {224'd0, held_mask});
          check("stall_flags", {254'd0, any_true, all_true}, {254'd0, held_flags});
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got result %h want no beat", result);
          end else begin
            mon_e = sb.pop_front();
            check("result_ones", result, expand(1'b1, mon_e.mode, mon_e.mask));
            check("result_zext", result0, expand(1'b0, mon_e.mode, mon_e.mask));
            check("lane_mask", {224'd0, lane_mask}, {224'd0, mon_e.mask});
            check("lane_mask_zext", {224'd0, lane_mask0}, {224'd0, mon_e.mask});
            check("any_all", {254'd0, any_true, all_true}, {254'd0, mon_e.any, mon_e.all});
            check("any_all_zext", {254'd0, any_true0, all_true0}, {254'd0, mon_e.any, mon_e.all});
          end
        end
      end
      prev_stall  = out_valid && !out_ready;
      held_result = result;
      held_mask   = lane_mask;
      held_flags  = {any_true, all_true};
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [2:0] op, input logic sg,
                      input logic [255:0] va, input logic [255:0] vb,
                      input logic [31:0] emask, input logic eany, input logic eall);
    exp_t e;
    int n;
    in_valid = 1'b1; data_mode = m; cmp_op = op; signed_cmp = sg; a = va; b = vb;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.mode = m; e.mask = emask; e.any = eany; e.all = eall;
        sb.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got in_ready 0 want 1");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; data_mode = 2'd0; cmp_op = 3'd0; signed_cmp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {255'd0, out_valid}, 256'd0);
    check("reset_in_ready", {255'd0, in_ready}, 256'd0);
    check("reset_result", result, 256'd0);
    check("reset_mask_flags", {222'd0, lane_mask, any_true, all_true}, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {255'd0, in_ready}, 256'd1);
    @(posedge clk); #1;

    // 8-bit unsigned GT: 0x80 > 0x7F in lane 0 only
    send(2'd0, 3'd2, 1'b0, {{31{8'h11}}, 8'h80}, {{31{8'h11}}, 8'h7F}, 32'h1, 1'b1, 1'b0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", 256'(lat), 256'd2);
    @(posedge clk); #1;
    send(2'd0, 3'd2, 1'b1, {{31{8'h11}}, 8'h80}, {{31{8'h11}}, 8'h7F}, 32'h0, 1'b0, 1'b0);
    send(2'd0, 3'd4, 1'b1, {{31{8'h11}}, 8'h80}, {{31{8'h11}}, 8'h7F}, 32'h1, 1'b1, 1'b0);
    send(2'd3, 3'd0, 1'b0, {4{64'hDEADBEEF_00000001}}, {4{64'hDEADBEEF_00000001}},
         32'hF, 1'b1, 1'b1);
    send(2'd2, 3'd1, 1'b0, 256'd0, 256'd1 << 96, 32'h8, 1'b1, 1'b0);
    send(2'd1, 3'd2, 1'b1, {16{16'h0001}}, {16{16'hFFFF}}, 32'h0000FFFF, 1'b1, 1'b1);
    send(2'd1, 3'd2, 1'b0, {16{16'h0001}}, {16{16'hFFFF}}, 32'h0, 1'b0, 1'b0);
    send(2'd3, 3'd2, 1'b0, {{3{64'h5}}, 64'h00000001_00000000},
         {{3{64'h5}}, 64'h00000000_FFFFFFFF}, 32'h1, 1'b1, 1'b0);
    send(2'd3, 3'd5, 1'b1, {4{64'h80000000_00000000}}, {4{64'h7FFFFFFF_FFFFFFFF}},
         32'hF, 1'b1, 1'b1);
    drain();

    // Back-pressure: five mixed beats, consumer stalled for four cycles
    out_ready = 1'b0;
    fork
      begin
        send(2'd0, 3'd3, 1'b0, 256'd0, 256'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
        send(2'd2, 3'd4, 1'b1, {8{32'hFFFFFFFE}}, {8{32'hFFFFFFFF}}, 32'hFF, 1'b1, 1'b1);
        send(2'd1, 3'd0, 1'b0, 256'd0, {{15{16'h0}}, 16'h0100}, 32'hFFFE, 1'b1, 1'b0);
        send(2'd3, 3'd1, 1'b0, {4{64'h1234}}, {4{64'h1234}}, 32'h0, 1'b0, 1'b0);
        send(2'd0, 3'd5, 1'b0, {32{8'h01}}, {32{8'h00}}, 32'h0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_full", {255'd0, in_ready}, 256'd0);
        check("bp_out_valid", {255'd0, out_valid}, 256'd1);
        @(negedge clk);
        check("bp_in_ready_hold", {255'd0, in_ready}, 256'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reserved opcode, then GE on equal 16-bit operands
    send(2'd0, 3'd7, 1'b0, {32{8'h5A}}, {32{8'h3C}}, 32'h0, 1'b0, 1'b0);
    send(2'd1, 3'd3, 1'b0, {16{16'hABCD}}, {16{16'hABCD}}, 32'h0000FFFF, 1'b1, 1'b1);
    drain();

    // Reset with two beats in flight; neither may ever emerge
    out_ready = 1'b0;
    send(2'd0, 3'd0, 1'b0, 256'd0, 256'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
    send(2'd0, 3'd1, 1'b0, 256'd0, 256'd1, 32'h1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", {255'd0, out_valid}, 256'd0);
    check("rst_mid_result", result, 256'd0);
    check("rst_mid_mask_flags", {222'd0, lane_mask, any_true, all_true}, 256'd0);
    check("rst_mid_in_ready", {255'd0, in_ready}, 256'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'd2, 3'd4, 1'b0, {8{32'h1}}, {8{32'h2}}, 32'hFF, 1'b1, 1'b1);
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
